bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
- Shares one iterative binary-to-BCD converter between NCH countdown channels, e.g. the main-road and side-road phase timers.
- Each channel requests a conversion of a 5-bit value. The block grants requesters round-robin and drives the converter's count and enable inputs.
- It waits for a valid result, applies the units==10 correction, and latches per-channel tens/units for the 7-segment drivers.

Parameters:
- NCH, 2, number of requesting channels (2..4).
- SETTLE, 2, cycles after driving a new count before conv_valid is trusted.
- TIMEOUT, 15, max cycles in WAIT before abort; must be ≥ SETTLE+4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NCH  per-channel conversion request (level, held until ack)
- req_val  in  5*NCH  per-channel binary value 0..31; channel i at [5i+4:5i]
- ack  out  NCH  one-cycle pulse; channel's result registers updated this cycle
- err  out  NCH  sticky timeout flag per channel, cleared by a successful ack on that channel
- ch_tens  out  4*NCH  latched BCD tens per channel
- ch_units  out  4*NCH  latched BCD units per channel
- conv_en  out  1  converter enable
- conv_count  out  5  converter binary input
- conv_valid  in  1  converter result-valid
- conv_tens  in  4  converter tens
- conv_units  in  4  converter units
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; ack=0, err=0, ch_tens=0, ch_units=0, conv_en=0, conv_count=0, busy=0; round-robin pointer=0.
- FSM states and transitions:
  - IDLE: if any req is set, grant the first set req at or after the pointer, cyclically. Register its req_val into conv_count, go LOAD.
  - LOAD: conv_en=1; go SETTLE.
  - SETTLE: conv_en=1; count SETTLE cycles, then go WAIT. conv_valid is ignored here, because the converter can report stale valid in the cycle after a count change.
  - WAIT: conv_en=1. If conv_valid, go CAPTURE. If the wait counter reaches TIMEOUT, set err[g], go IDLE without ack.
  - CAPTURE: apply the correction below, write ch_tens/ch_units for channel g, pulse ack[g], drop conv_en, advance pointer to g+1 mod NCH, go IDLE.
- Correction rule: the converter's loop stops at units≤10, so it can return units=10 for values 10, 20, 30.
  - If conv_units==10: store tens=conv_tens+1 and units=0.
  - Otherwise store the converter outputs unchanged.
  - Any conv_units in 11..15 is a converter fault: set err[g] and still ack with the raw values.
- conv_count holds its value between grants. Re-presenting the same value is legal: the converter holds its previous result, and the SETTLE+WAIT path still completes.
- Latency from req (IDLE, no contention) to ack:
  - Nominal: 1 + 1 + SETTLE + W + 1 cycles, where W is the converter iteration count, 0..3 for values ≤31.
  - Value 31 with SETTLE=2: ack 8 cycles after req first seen.
- req dropped by the requester before ack: the conversion in flight completes and its result is latched; ack still pulses.
- req_val changing after grant is not seen; the value was registered in IDLE.
- Simultaneous requests from all channels: each is served once, in pointer order; no channel waits more than NCH-1 conversions.
- Same-cycle ack and new req on the same channel: the new req is seen in the following IDLE cycle.
- Reset mid-conversion: everything returns to reset values immediately; the converter is not otherwise flushed.
- Arithmetic: the tens+1 correction never exceeds 3. The wait counter is 4 bits wide and saturates.

Decomposition:
- Package bcd_arb_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, WAIT, CAPTURE);
  - BCD_W=4 and BIN_W=5 constants;
  - the UNITS_OVF=10 correction constant.
- One sub-module, rr_pick: combinational round-robin picker with NCH-bit req, pointer in, one-hot grant and index out.

Test Plan:
- Single request ch0 value 31 (valid 3 cycles after SETTLE) -> ack[0] at cycle 8; ch_tens0=3, ch_units0=1; err=0.
- Value 20, converter returns tens=1 units=10 -> stored ch_tens=2, ch_units=0; value 10 -> 1,0; value 9 -> 0,9.
- req=2'b11 held, ch0=17, ch1=25 -> ch0 acked first, then ch1; next round starts at ch0 after ch1 is served. Both results correct.
- conv_valid forced low -> err[g] sets after TIMEOUT cycles in WAIT, no ack. A later successful conversion on that channel clears err[g].
- conv_valid high during SETTLE with stale data -> ignored; only the post-SETTLE value is latched.
- rst_n asserted in WAIT -> all outputs are 0 the same cycle; after release the next req is served normally from pointer 0.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD converter arbiter.
//   state_t   : arbiter FSM states
//   BCD_W     : width of one BCD digit
//   BIN_W     : width of a channel's binary count value
//   UNITS_OVF : units value the iterative converter can leave behind (10)
package bcd_arb_pkg;

  localparam int BCD_W = 4;
  localparam int BIN_W = 5;

  localparam logic [BCD_W-1:0] UNITS_OVF = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : per-channel request vector
//   ptr   : channel with highest priority this round
//   grant : one-hot grant (all zero when nothing requests)
//   idx   : index of the granted channel (0 when nothing requests)
module rr_pick #(
  parameter int NCH = 2,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  idx
);

  localparam int SW = IW + 1;

  logic [2*NCH-1:0] req2;
  logic [NCH-1:0]   rot;
  logic             found;
  logic [SW-1:0]    sum;

  // Rotate the requests so bit 0 is the pointer's channel, take the first
  // set bit, then map the rotated position back to a channel index.
  always_comb begin
    req2  = {req, req};
    rot   = NCH'(req2 >> ptr);
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + SW'(k);
        idx   = (sum >= SW'(NCH)) ? IW'(sum - SW'(NCH)) : IW'(sum);
      end
    end
    grant = '0;
    for (int c = 0; c < NCH; c++) begin
      grant[c] = found && (idx == IW'(c));
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: shares one iterative binary-to-BCD converter between
// NCH countdown channels and latches each channel's tens/units digits.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req / req_val         : per-channel level request and 5-bit value
//   ack                   : one-cycle pulse, channel's digits hold the new result
//   err                   : sticky per-channel timeout / converter-fault flag
//   ch_tens / ch_units    : latched BCD digits, 4 bits per channel
//   conv_en / conv_count  : drive to the shared converter
//   conv_valid/tens/units : result from the shared converter
//   busy                  : high whenever a conversion is in progress
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no conversion; pick next requester, register its value
// ST_LOAD    | converter enabled with the new count
// ST_SETTLE  | SETTLE cycles where conv_valid may be stale and is ignored
// ST_WAIT    | wait for conv_valid, give up after TIMEOUT cycles
// ST_CAPTURE | ack the granted channel, advance round-robin pointer
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req,
  input  logic [BIN_W*NCH-1:0] req_val,
  output logic [NCH-1:0]       ack,
  output logic [NCH-1:0]       err,
  output logic [BCD_W*NCH-1:0] ch_tens,
  output logic [BCD_W*NCH-1:0] ch_units,
  output logic                 conv_en,
  output logic [BIN_W-1:0]     conv_count,
  input  logic                 conv_valid,
  input  logic [BCD_W-1:0]     conv_tens,
  input  logic [BCD_W-1:0]     conv_units,
  output logic                 busy
);

  localparam int              IW           = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0]      SETTLE_LAST  = 4'(SETTLE - 1);
  localparam logic [3:0]      TIMEOUT_LAST = 4'(TIMEOUT - 1);
  localparam logic [IW-1:0]   LAST_CH      = IW'(NCH - 1);

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, gidx, pick_idx;
  logic [NCH-1:0]     gmask, pick_grant;
  logic [3:0]         cnt;
  logic [BIN_W-1:0]   pick_val;
  logic [BCD_W-1:0]   cor_tens, cor_units;
  logic               units_bad;
  logic               take, abort;

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_idx == IW'(i)) pick_val = req_val[BIN_W*i +: BIN_W];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|req) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_SETTLE;
      ST_SETTLE:  if (cnt == SETTLE_LAST) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (conv_valid)                state_nxt = ST_CAPTURE;
        else if (cnt == TIMEOUT_LAST)  state_nxt = ST_IDLE;
      end
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    conv_en = 1'b0;
    busy    = 1'b1;
    ack     = '0;
    case (state)
      ST_IDLE:                     busy    = 1'b0;
      ST_LOAD, ST_SETTLE, ST_WAIT: conv_en = 1'b1;
      ST_CAPTURE:                  ack     = gmask;
      default:                     busy    = 1'b0;
    endcase
  end

  // Shared settle / wait counter; restarts on every state change and
  // saturates so a long stay can never wrap back into range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state != state_nxt) cnt <= '0;
    else if (cnt != 4'hF)        cnt <= cnt + 4'd1;
  end

  // Grant and count are captured once in IDLE; later req_val changes are
  // deliberately invisible to the conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gidx       <= '0;
      gmask      <= '0;
      conv_count <= '0;
      ptr        <= '0;
    end else begin
      if (state == ST_IDLE && |req) begin
        gidx       <= pick_idx;
        gmask      <= pick_grant;
        conv_count <= pick_val;
      end
      if (state == ST_CAPTURE) ptr <= (gidx == LAST_CH) ? '0 : gidx + 1'b1;
    end
  end

  // The converter's loop exits at units<=10, so 10/20/30 come back as
  // (tens-1, 10); fold that back into a proper BCD pair.
  always_comb begin
    cor_tens  = conv_tens;
    cor_units = conv_units;
    if (conv_units == UNITS_OVF) begin
      cor_tens  = conv_tens + 4'd1;
      cor_units = '0;
    end
  end

  assign units_bad = conv_units > UNITS_OVF;
  assign take      = (state == ST_WAIT) && conv_valid;
  assign abort     = (state == ST_WAIT) && !conv_valid && (cnt == TIMEOUT_LAST);

  // Digits are written on the WAIT->CAPTURE edge so they are already
  // visible during the ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= '0;
      ch_tens  <= '0;
      ch_units <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (gmask[i] && take) begin
          ch_tens[BCD_W*i +: BCD_W]  <= cor_tens;
          ch_units[BCD_W*i +: BCD_W] <= cor_units;
          err[i]                     <= units_bad;
        end else if (gmask[i] && abort) begin
          err[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: a small converter model drives
// the conv_* inputs, a reference model tracks expected digits, error flags
// and round-robin order from the plain decimal rules.
module tb_bcd_conv_arbiter;

  localparam int NCH     = 2;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   req;
  logic [5*NCH-1:0] req_val;
  logic [NCH-1:0]   ack;
  logic [NCH-1:0]   err;
  logic [4*NCH-1:0] ch_tens;
  logic [4*NCH-1:0] ch_units;
  logic             conv_en;
  logic [4:0]       conv_count;
  logic             conv_valid;
  logic [3:0]       conv_tens;
  logic [3:0]       conv_units;
  logic             busy;

  int n_err = 0;
  int n_chk = 0;

  int             ptr_m;
  logic [4:0]     vals  [NCH];
  logic [3:0]     exp_t [NCH];
  logic [3:0]     exp_u [NCH];
  logic [NCH-1:0] exp_e;

  int k_conv;
  int w_cur;
  bit en_prev, stale_on, fault_on, hang_on;

  bcd_conv_arbiter #(.NCH(NCH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_val    (req_val),
    .ack        (ack),
    .err        (err),
    .ch_tens    (ch_tens),
    .ch_units   (ch_units),
    .conv_en    (conv_en),
    .conv_count (conv_count),
    .conv_valid (conv_valid),
    .conv_tens  (conv_tens),
    .conv_units (conv_units),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Iterative converter behaviour: its loop stops at units<=10.
  function automatic logic [7:0] conv_raw(input logic [4:0] v);
    int t, u;
    t = int'(v) / 10;
    u = int'(v) % 10;
    if (u == 0 && t > 0) begin
      t = t - 1;
      u = 10;
    end
    return {4'(t), 4'(u)};
  endfunction

  function automatic int model_pick(input logic [NCH-1:0] r);
    for (int k = 0; k < NCH; k++) begin
      if (r[(ptr_m + k) % NCH]) return (ptr_m + k) % NCH;
    end
    return -1;
  endfunction

  task automatic set_val(input int ch, input logic [4:0] v);
    vals[ch] = v;
    req_val[5*ch +: 5] = v;
  endtask

  // One clock; afterwards the converter model updates its outputs for the
  // new cycle. k_conv counts cycles since conv_en rose (0 = first cycle).
  task automatic step();
    logic [7:0] r;
    @(posedge clk);
    #1;
    if (conv_en) k_conv = en_prev ? k_conv + 1 : 0;
    else         k_conv = 0;
    en_prev    = conv_en;
    conv_valid = 1'b0;
    conv_tens  = 4'($urandom);
    conv_units = 4'($urandom);
    if (conv_en && !hang_on && k_conv >= 2 + w_cur) begin
      conv_valid = 1'b1;
      if (fault_on) begin
        conv_tens  = 4'd1;
        conv_units = 4'd12;
      end else begin
        r          = conv_raw(conv_count);
        conv_tens  = r[7:4];
        conv_units = r[3:0];
      end
    end else if (conv_en && stale_on && k_conv < 3) begin
      conv_valid = 1'b1;
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("ch_tens%0d", i),  ch_tens[4*i +: 4],  exp_t[i]);
      chk($sformatf("ch_units%0d", i), ch_units[4*i +: 4], exp_u[i]);
    end
    chk("err_vec", err, exp_e);
  endtask

  // Serve one conversion starting from an IDLE cycle with req already set.
  // w: WAIT cycle (1-based) in which the converter reports valid.
  task automatic serve(input int w, input bit stale, input bit fault, input bit hang,
                       input bit drop, input bit perturb);
    int         g;
    int         n;
    bit         done;
    logic [4:0] v;
    g = model_pick(req);
    if (g < 0) begin
      chk("grant_exists", 32'(g), 32'd0);
      return;
    end
    v        = vals[g];
    w_cur    = w;
    stale_on = stale;
    fault_on = fault;
    hang_on  = hang;
    done     = 1'b0;
    n        = 0;
    while (!done && n < 40) begin
      step();
      n++;
      if (n == 1) chk("busy_load", busy, 1);
      if (perturb && n == 2) begin
        req[g] = 1'b0;
        set_val(g, v ^ 5'h1F);
      end
      if (ack != '0 || (hang && err[g])) done = 1'b1;
    end
    chk("finished", done, 1);
    if (hang) begin
      chk("timeout_lat", n, 2 + SETTLE + TIMEOUT);
      chk("timeout_noack", ack, 0);
      exp_e[g] = 1'b1;
    end else begin
      chk("ack_onehot", ack, 1 << g);
      chk("ack_lat", n, 2 + SETTLE + w);
      chk("count_held", conv_count, v);
      if (fault) begin
        exp_t[g] = 4'd1;
        exp_u[g] = 4'd12;
        exp_e[g] = 1'b1;
      end else begin
        exp_t[g] = 4'(v / 10);
        exp_u[g] = 4'(v % 10);
        exp_e[g] = 1'b0;
      end
      ptr_m = (g + 1) % NCH;
    end
    if (drop) req[g] = 1'b0;
    step();
    chk("ack_pulse", ack, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int ch;
    rst_n      = 1'b0;
    req        = '0;
    req_val    = '0;
    conv_valid = 1'b0;
    conv_tens  = '0;
    conv_units = '0;
    ptr_m      = 0;
    exp_e      = '0;
    k_conv     = 0;
    w_cur      = 1;
    en_prev    = 1'b0;
    stale_on   = 1'b0;
    fault_on   = 1'b0;
    hang_on    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      vals[i]  = '0;
      exp_t[i] = '0;
      exp_u[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conv_en", conv_en, 0);
    chk("rst_conv_count", conv_count, 0);
    check_regs();
    rst_n = 1'b1;
    step();

    // Value 31, valid in the third WAIT cycle: ack in cycle 8.
    set_val(0, 5'd31); req[0] = 1'b1; serve(3, 0, 0, 0, 1, 0); check_regs();
    // Units==10 correction and plain values.
    set_val(1, 5'd20); req[1] = 1'b1; serve(2, 1, 0, 0, 1, 0); check_regs();
    set_val(0, 5'd10); req[0] = 1'b1; serve(1, 0, 0, 0, 1, 0); check_regs();
    set_val(1, 5'd9);  req[1] = 1'b1; serve(2, 0, 0, 0, 1, 0); check_regs();
    set_val(0, 5'd30); req[0] = 1'b1; serve(1, 1, 0, 0, 1, 0); check_regs();
    set_val(1, 5'd0);  req[1] = 1'b1; serve(3, 1, 0, 0, 1, 0); check_regs();

    // Both channels held: round-robin ch0, ch1, ch0.
    set_val(0, 5'd17); set_val(1, 5'd25); req = 2'b11;
    serve(2, 1, 0, 0, 0, 0); check_regs();
    serve(3, 0, 0, 0, 0, 0); check_regs();
    serve(1, 0, 0, 0, 1, 0); check_regs();
    req = '0;

    // Timeout on ch1, then a good conversion clears its err.
    set_val(1, 5'd13); req[1] = 1'b1; serve(1, 1, 0, 1, 1, 0); check_regs();
    req[1] = 1'b1; serve(2, 0, 0, 0, 1, 0); check_regs();

    // Converter fault on ch0 (units=12), then recovery.
    set_val(0, 5'd7); req[0] = 1'b1; serve(1, 0, 1, 0, 1, 0); check_regs();
    req[0] = 1'b1; serve(2, 0, 0, 0, 1, 0); check_regs();

    // req dropped and req_val changed after grant.
    set_val(1, 5'd22); req[1] = 1'b1; serve(2, 1, 0, 0, 0, 1); check_regs();

    // Random single and paired requests.
    for (int i = 0; i < 12; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      set_val(ch, 5'($urandom_range(0, 31)));
      req[ch] = 1'b1;
      serve(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 0, 0, 1, 0);
      check_regs();
    end
    for (int i = 0; i < 4; i++) begin
      set_val(0, 5'($urandom_range(0, 31)));
      set_val(1, 5'($urandom_range(0, 31)));
      req = 2'b11;
      serve(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 0, 0, 1, 0);
      check_regs();
      serve(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 0, 0, 1, 0);
      check_regs();
    end

    // Leave the pointer at ch1, then reset while ch1 sits in WAIT.
    set_val(0, 5'd4); req[0] = 1'b1; serve(1, 0, 0, 0, 1, 0); check_regs();
    set_val(1, 5'd5); req[1] = 1'b1;
    w_cur = 3; stale_on = 1'b0; fault_on = 1'b0; hang_on = 1'b0;
    repeat (5) step();
    chk("pre_rst_conv_en", conv_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_conv_en", conv_en, 0);
    chk("mid_rst_conv_count", conv_count, 0);
    for (int i = 0; i < NCH; i++) begin
      exp_t[i] = '0;
      exp_u[i] = '0;
    end
    exp_e = '0;
    ptr_m = 0;
    check_regs();
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    set_val(0, 5'd14); set_val(1, 5'd28); req = 2'b11;
    serve(2, 0, 0, 0, 1, 0); check_regs();
    serve(1, 1, 0, 0, 1, 0); check_regs();
    req = '0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
